// File: rtl/lcd_screen_refresh.sv
// lcd_screen_refresh: walks two 16-character LCD lines out of the RAM controller
// and streams them to the LCD driver as 0x80, 16 chars, 0xC0, 16 chars.
// Latency: start -> first byte valid next cycle; each char costs FETCH/WAIT/CAPT
// plus SEND until lcd_ready. Backpressure: lcd_valid/lcd_data/lcd_rs hold
// unchanged until lcd_ready; the FSM waits indefinitely.
//
// Ports:
//   clk, reset (sync, active-high), start
//   line{0,1}_sel/_menu/_half : per-line RAM source, snapshotted on start
//   ram_sel, menu_select, ram_add -> RAM controller; ram_dout <- (1-cycle latency)
//   lcd_data, lcd_rs, lcd_valid -> LCD driver; lcd_ready <- LCD driver
//   busy (refresh in progress), done (1-cycle pulse at completion)
//
// Optional feature: define LCD_REFRESH_AUTO_EN to self-start a refresh after
// REFRESH_PERIOD idle cycles using the live line* inputs.

module lcd_screen_refresh #(
  parameter int REFRESH_PERIOD = 1000000,
  parameter int LINE_LEN       = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] line0_sel,
  input  logic [1:0] line1_sel,
  input  logic [4:0] line0_menu,
  input  logic [4:0] line1_menu,
  input  logic       line0_half,
  input  logic       line1_half,
  output logic [1:0] ram_sel,
  output logic [4:0] menu_select,
  output logic [4:0] ram_add,
  input  logic [7:0] ram_dout,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_valid,
  input  logic       lcd_ready,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_FETCH, S_WAIT, S_CAPT, S_SEND, S_NEXT
  } state_t;

  typedef struct packed {
    logic [1:0] sel;
    logic [4:0] menu;
    logic       half;
  } line_cfg_t;

  localparam logic [3:0] LAST_COL = 4'(LINE_LEN - 1);

  state_t     state_q, state_d;
  logic [3:0] col_q, col_d;
  logic       line_q, line_d;
  line_cfg_t  cfg0_q, cfg0_d, cfg1_q, cfg1_d;
  logic [1:0] ram_sel_q, ram_sel_d;
  logic [4:0] menu_select_q, menu_select_d;
  logic [4:0] ram_add_q, ram_add_d;
  logic [7:0] lcd_data_q, lcd_data_d;
  logic       lcd_rs_q, lcd_rs_d;
  logic       lcd_valid_q, lcd_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       start_go;
  logic       auto_go;
  line_cfg_t  cur_cfg;
  logic       xfer;

  assign xfer    = lcd_valid_q && lcd_ready;
  assign cur_cfg = line_q ? cfg1_q : cfg0_q;

`ifdef LCD_REFRESH_AUTO_EN
  localparam int CNT_W = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign auto_go = (state_q == S_IDLE) && !done_q &&
                   (cnt_q == CNT_W'(REFRESH_PERIOD - 1));

  // Counts only while idle; any start, done, or busy period clears it.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_IDLE && !done_q && !start_go) cnt_d = cnt_q + 1'b1;
  end
`else
  assign auto_go = 1'b0;
`endif

  // A start in the done cycle is dropped so back-to-back refreshes need a fresh request.
  assign start_go = (state_q == S_IDLE) && !done_q && (start || auto_go);

  always_comb begin
    state_d       = state_q;
    col_d         = col_q;
    line_d        = line_q;
    cfg0_d        = cfg0_q;
    cfg1_d        = cfg1_q;
    ram_sel_d     = ram_sel_q;
    menu_select_d = menu_select_q;
    ram_add_d     = ram_add_q;
    lcd_data_d    = lcd_data_q;
    lcd_rs_d      = lcd_rs_q;
    lcd_valid_d   = lcd_valid_q;
    busy_d        = busy_q;
    done_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          cfg0_d      = '{sel: line0_sel, menu: line0_menu, half: line0_half};
          cfg1_d      = '{sel: line1_sel, menu: line1_menu, half: line1_half};
          line_d      = 1'b0;
          busy_d      = 1'b1;
          lcd_data_d  = 8'h80;
          lcd_rs_d    = 1'b0;
          lcd_valid_d = 1'b1;
          state_d     = S_CMD;
        end
      end
      S_CMD: begin
        if (xfer) begin
          lcd_valid_d   = 1'b0;
          col_d         = 4'd0;
          ram_sel_d     = cur_cfg.sel;
          menu_select_d = cur_cfg.menu;
          ram_add_d     = {cur_cfg.half, 4'd0};
          state_d       = S_FETCH;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT:  state_d = S_CAPT;
      S_CAPT: begin
        // Non-printable bytes become spaces so the panel never sees control codes.
        lcd_data_d  = (ram_dout >= 8'h20 && ram_dout <= 8'h7E) ? ram_dout : 8'h20;
        lcd_rs_d    = 1'b1;
        lcd_valid_d = 1'b1;
        state_d     = S_SEND;
      end
      S_SEND: begin
        if (xfer) begin
          lcd_valid_d = 1'b0;
          state_d     = S_NEXT;
        end
      end
      S_NEXT: begin
        if (col_q == LAST_COL) begin
          if (!line_q) begin
            line_d      = 1'b1;
            lcd_data_d  = 8'hC0;
            lcd_rs_d    = 1'b0;
            lcd_valid_d = 1'b1;
            state_d     = S_CMD;
          end else begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else begin
          col_d     = col_q + 4'd1;
          ram_add_d = {cur_cfg.half, col_q + 4'd1};
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      col_q         <= 4'd0;
      line_q        <= 1'b0;
      cfg0_q        <= '0;
      cfg1_q        <= '0;
      ram_sel_q     <= 2'd0;
      menu_select_q <= 5'd0;
      ram_add_q     <= 5'd0;
      lcd_data_q    <= 8'h00;
      lcd_rs_q      <= 1'b0;
      lcd_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
`ifdef LCD_REFRESH_AUTO_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      line_q        <= line_d;
      cfg0_q        <= cfg0_d;
      cfg1_q        <= cfg1_d;
      ram_sel_q     <= ram_sel_d;
      menu_select_q <= menu_select_d;
      ram_add_q     <= ram_add_d;
      lcd_data_q    <= lcd_data_d;
      lcd_rs_q      <= lcd_rs_d;
      lcd_valid_q   <= lcd_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
`ifdef LCD_REFRESH_AUTO_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign ram_sel     = ram_sel_q;
  assign menu_select = menu_select_q;
  assign ram_add     = ram_add_q;
  assign lcd_data    = lcd_data_q;
  assign lcd_rs      = lcd_rs_q;
  assign lcd_valid   = lcd_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_lcd_screen_refresh.sv
// tb_lcd_screen_refresh: scoreboard bench for lcd_screen_refresh.
// Each accepted start pushes the 34 expected LCD bytes built from a RAM model;
// a negedge monitor pops and compares on every lcd_valid&&lcd_ready.
`timescale 1ns/1ps
module tb_lcd_screen_refresh;

`ifdef LCD_REFRESH_AUTO_EN
  localparam int PERIOD = 100;
`else
  localparam int PERIOD = 1000000;
`endif

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] line0_sel, line1_sel;
  logic [4:0] line0_menu, line1_menu;
  logic       line0_half, line1_half;
  logic [1:0] ram_sel;
  logic [4:0] menu_select, ram_add;
  logic [7:0] ram_dout;
  logic [7:0] lcd_data;
  logic       lcd_rs, lcd_valid, lcd_ready, busy, done;

  always #5 clk = ~clk;

  lcd_screen_refresh #(.REFRESH_PERIOD(PERIOD), .LINE_LEN(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .line0_sel(line0_sel), .line1_sel(line1_sel),
    .line0_menu(line0_menu), .line1_menu(line1_menu),
    .line0_half(line0_half), .line1_half(line1_half),
    .ram_sel(ram_sel), .menu_select(menu_select), .ram_add(ram_add),
    .ram_dout(ram_dout), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
    .lcd_valid(lcd_valid), .lcd_ready(lcd_ready), .busy(busy), .done(done)
  );

  // RAM contents: 32 menus, a remote and a local page, 32 bytes each.
  logic [7:0] menu_mem [32][32];
  logic [7:0] remote_mem [32];
  logic [7:0] local_mem [32];

  function automatic logic [7:0] mem_rd(logic [1:0] s, logic [4:0] m, logic [4:0] a);
    case (s)
      2'd0:    return menu_mem[m][a];
      2'd1:    return remote_mem[a];
      2'd2:    return local_mem[a];
      default: return 8'h00;
    endcase
  endfunction

  // Registered read: data follows the address by one clock.
  always @(posedge clk) ram_dout <= mem_rd(ram_sel, menu_select, ram_add);

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected stream: {rs, byte}.
  logic [8:0] exp_q[$];

  function automatic logic [7:0] printable(logic [7:0] b);
    return (b >= 8'h20 && b <= 8'h7E) ? b : 8'h20;
  endfunction

  task automatic push_refresh(logic [1:0] s0, logic [4:0] m0, logic h0,
                              logic [1:0] s1, logic [4:0] m1, logic h1);
    exp_q.push_back({1'b0, 8'h80});
    for (int c = 0; c < 16; c++)
      exp_q.push_back({1'b1, printable(mem_rd(s0, m0, 5'(h0 * 16 + c)))});
    exp_q.push_back({1'b0, 8'hC0});
    for (int c = 0; c < 16; c++)
      exp_q.push_back({1'b1, printable(mem_rd(s1, m1, 5'(h1 * 16 + c)))});
  endtask

  // LCD driver model: 0 = always ready, 1 = random, 2 = stalled.
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       lcd_ready = 1'b1;
      1:       lcd_ready = ($urandom_range(0, 3) != 0);
      default: lcd_ready = 1'b0;
    endcase
  end

  // Monitor.
  int xfer_cnt = 0;
  int done_cnt = 0;
  int stall_cycles = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_byte = '0;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        stall_cycles++;
        chk("stall_valid_hold", lcd_valid, 1);
        chk("stall_data_hold", {lcd_rs, lcd_data}, prev_byte);
      end
      if (!busy) chk("valid_low_when_idle", lcd_valid, 0);
      if (lcd_valid && lcd_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_xfer: got %0h expected none", {lcd_rs, lcd_data});
        end else begin
          chk("xfer_byte", {lcd_rs, lcd_data}, exp_q.pop_front());
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_queue_empty", exp_q.size(), 0);
      end
      prev_stall = lcd_valid && !lcd_ready;
      prev_byte  = {lcd_rs, lcd_data};
    end
  end

  task automatic check_reset_outputs(string tag);
    chk({tag, "_ram_sel"}, ram_sel, 0);
    chk({tag, "_menu_select"}, menu_select, 0);
    chk({tag, "_ram_add"}, ram_add, 0);
    chk({tag, "_lcd_data"}, lcd_data, 0);
    chk({tag, "_lcd_rs"}, lcd_rs, 0);
    chk({tag, "_lcd_valid"}, lcd_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  int done_base = 0;

  // Call at posedge+1 with the DUT idle and not in its done cycle.
  task automatic do_start(logic [1:0] s0, logic [4:0] m0, logic h0,
                          logic [1:0] s1, logic [4:0] m1, logic h1);
    line0_sel = s0; line0_menu = m0; line0_half = h0;
    line1_sel = s1; line1_menu = m1; line1_half = h1;
    push_refresh(s0, m0, h0, s1, m1, h1);
    xfer_cnt  = 0;
    done_base = done_cnt;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    // Scramble inputs; the snapshot must be what gets displayed.
    line0_sel = 2'($urandom_range(0, 2)); line0_menu = 5'($urandom); line0_half = 1'($urandom);
    line1_sel = 2'($urandom_range(0, 2)); line1_menu = 5'($urandom); line1_half = 1'($urandom);
  endtask

  // Returns at posedge+1 of the done cycle.
  task automatic wait_done(int budget);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (done) seen = 1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got no done expected done within %0d cycles", budget);
    end else begin
      chk("xfers_per_refresh", xfer_cnt, 34);
      chk("busy_cleared_with_done", busy, 0);
    end
  endtask

  task automatic wait_xfer(int n, bit need_valid);
    int k = 0;
    while (!(xfer_cnt >= n && (!need_valid || lcd_valid)) && k < 2000) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 2000) begin
      n_checks++;
      n_fail++;
      $display("FAIL xfer_wait_timeout: got %0d transfers expected %0d", xfer_cnt, n);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    string s_main, s_disp;
    int    sc;
    bit    seen;

    for (int m = 0; m < 32; m++)
      for (int a = 0; a < 32; a++) menu_mem[m][a] = 8'($urandom);
    for (int a = 0; a < 32; a++) begin
      remote_mem[a] = 8'($urandom);
      local_mem[a]  = 8'($urandom);
    end
    s_main = "MAIN MENU MASTER";
    s_disp = "Display Local   ";
    for (int i = 0; i < 16; i++) begin
      menu_mem[0][i] = s_main[i];
      menu_mem[3][i] = s_disp[i];
    end

    reset = 1'b1; start = 1'b0; lcd_ready = 1'b1;
    line0_sel = 0; line0_menu = 0; line0_half = 0;
    line1_sel = 0; line1_menu = 0; line1_half = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    // Reset wins over start.
    start = 1'b1;
    @(posedge clk); #1;
    chk("reset_beats_start", busy, 0);
    start = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // Fixed menu text, driver always ready.
    ready_mode = 0;
    do_start(2'd0, 5'd0, 1'b0, 2'd0, 5'd3, 1'b0);
    wait_done(1000);
    chk("one_done_menu", done_cnt - done_base, 0); // monitor counts at negedge
    @(posedge clk); #1;
    chk("one_done_menu_after", done_cnt - done_base, 1);

    // Non-printable byte in local page, upper half.
    local_mem[20] = 8'h07;
    local_mem[21] = 8'h41;
    local_mem[22] = 8'h7F;
    do_start(2'd1, 5'($urandom), 1'b0, 2'd2, 5'($urandom), 1'b1);
    wait_done(1000);

    // Random sources with a random ready; each next start one cycle after done.
    ready_mode = 1;
    for (int t = 0; t < 6; t++) begin
      @(posedge clk); #1;
      do_start(2'($urandom_range(0, 2)), 5'($urandom), 1'($urandom),
               2'($urandom_range(0, 2)), 5'($urandom), 1'($urandom));
      wait_done(3000);
    end

    // Start in the done cycle must be dropped.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    repeat (20) begin
      if (busy) seen = 1;
      @(posedge clk); #1;
    end
    chk("start_in_done_cycle_ignored", seen, 0);

    // Long stall on a character of line 0.
    ready_mode = 0;
    do_start(2'd0, 5'($urandom), 1'b0, 2'd1, 5'($urandom), 1'b0);
    wait_xfer(6, 1'b0);
    sc = stall_cycles;
    ready_mode = 2;
    repeat (50) @(posedge clk);
    #1;
    chk("stall_observed", (stall_cycles - sc) >= 40, 1);
    chk("stall_no_progress", xfer_cnt, 6);
    ready_mode = 0;
    wait_done(1000);

    // Start while busy must be ignored.
    @(posedge clk); #1;
    ready_mode = 1;
    do_start(2'd2, 5'($urandom), 1'b1, 2'd0, 5'($urandom), 1'b1);
    wait_xfer(10, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(3000);
    repeat (20) @(posedge clk);
    #1;
    chk("busy_start_one_done", done_cnt - done_base, 1);
    chk("busy_start_not_queued", busy, 0);

    // Reset with a byte pending.
    ready_mode = 0;
    do_start(2'd0, 5'($urandom), 1'b1, 2'd1, 5'($urandom), 1'b1);
    wait_xfer(20, 1'b1);
    chk("reset_at_xfer", xfer_cnt, 20);
    chk("reset_with_valid", lcd_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("midreset");
    reset = 1'b0;
    exp_q.delete();
    done_base = done_cnt;
    repeat (50) @(posedge clk);
    #1;
    chk("no_done_after_abort", done_cnt - done_base, 0);
    chk("idle_after_abort", busy, 0);
    do_start(2'd1, 5'($urandom), 1'b0, 2'd2, 5'($urandom), 1'b0);
    wait_done(1000);

`ifdef LCD_REFRESH_AUTO_EN
    begin
      int n = 0;
      seen = 0;
      push_refresh(line0_sel, line0_menu, line0_half, line1_sel, line1_menu, line1_half);
      xfer_cnt = 0;
      while (!seen && n < 300) begin
        @(posedge clk); #1;
        n++;
        if (busy) seen = 1;
      end
      chk("auto_start_delay", n, PERIOD + 1);
      wait_done(1000);
    end
`else
    seen = 0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (busy) seen = 1;
    end
    chk("no_auto_refresh", seen, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd_screen_refresh.md
LCD_SCREEN_REFRESH -- requirements
Module: lcd_screen_refresh

Interface
REQ-001 SHALL have parameter REFRESH_PERIOD, default 1000000: idle clk cycles between automatic refreshes (used only under LCD_REFRESH_AUTO_EN).
REQ-002 SHALL have parameter LINE_LEN, default 16: characters per LCD line. Fixed at 16 for this revision.
REQ-003 clk  in  1  sole clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  request a full-screen refresh.
REQ-006 line0_sel / line1_sel  in  2 each  RAM select for the line: 0 menu, 1 remote, 2 local.
REQ-007 line0_menu / line1_menu  in  5 each  menu index for the line, used when its sel=0.
REQ-008 line0_half / line1_half  in  1 each  RAM half for the line: 0 = addresses 0-15, 1 = addresses 16-31.
REQ-009 ram_sel  out  2  drives the RAM controller's RAM select.
REQ-010 menu_select  out  5  drives the RAM controller's menu select.
REQ-011 ram_add  out  5  drives the RAM controller's read address.
REQ-012 ram_dout  in  8  read data from the RAM controller; registered, valid 1 cycle after address.
REQ-013 lcd_data  out  8  character or command byte to the LCD driver.
REQ-014 lcd_rs  out  1  1 = character, 0 = command.
REQ-015 lcd_valid  out  1  lcd_data/lcd_rs are valid.
REQ-016 lcd_ready  in  1  LCD driver accepts a byte this cycle.
REQ-017 busy  out  1  refresh in progress.
REQ-018 done  out  1  one-cycle pulse when a refresh completes.

Function
REQ-019 SHALL implement FSM states IDLE, CMD, FETCH, WAIT, CAPT, SEND, and NEXT.
REQ-020 In IDLE, start=1 SHALL snapshot all line* inputs, set busy=1 and line=0, and go to CMD. line* changes after this SHALL be ignored until the next start.
REQ-021 CMD SHALL present lcd_rs=0 with lcd_data=0x80 (line 0) or 0xC0 (line 1) and lcd_valid=1, holding them until lcd_valid&&lcd_ready; it SHALL then set col=0 and go to FETCH.
REQ-022 In FETCH, ram_sel and menu_select SHALL take the snapshot for the current line, and ram_add SHALL be {half,col[3:0]}.
REQ-023 The address SHALL be held through FETCH, WAIT, and CAPT; CAPT SHALL latch ram_dout, 2 cycles after FETCH entry.
REQ-024 Captured byte b SHALL be sent as-is if 0x20<=b<=0x7E, else replaced by 0x20.
REQ-025 SEND SHALL present lcd_rs=1 with the byte and lcd_valid=1. lcd_data, lcd_rs, and lcd_valid SHALL NOT change until lcd_valid&&lcd_ready.
REQ-026 NEXT after col 15 of line 0 SHALL go to CMD for line 1.
REQ-027 NEXT after col 15 of line 1 SHALL go to IDLE, pulse done=1 for 1 cycle, and clear busy in the same cycle.
REQ-028 NEXT in all other cases SHALL increment col and go to FETCH.
REQ-029 Each refresh SHALL produce exactly 34 LCD transfers, in order: 0x80, 16 chars, 0xC0, 16 chars.
REQ-030 lcd_valid SHALL be 0 in IDLE, FETCH, WAIT, CAPT, and NEXT.
REQ-031 start while busy=1 SHALL be ignored and not queued.
REQ-032 start in the same cycle as done SHALL be ignored; start on the cycle after done SHALL begin a new refresh.
REQ-033 A stalled lcd_ready SHALL hold the FSM indefinitely, with no timeout.
REQ-034 col SHALL be 4-bit; the wrap from 15 SHALL never be reached, because line change occurs in NEXT.

Reset
REQ-035 reset=1 SHALL, on the next edge, force IDLE and set col=0, line=0, ram_sel=0, menu_select=0, ram_add=0, lcd_data=0x00, lcd_rs=0, lcd_valid=0, busy=0, done=0, and the auto counter to 0.
REQ-036 Reset mid-refresh, including with lcd_valid high and unacknowledged, SHALL abort the refresh; no done pulse SHALL follow.
REQ-037 reset SHALL take priority over start.

Configuration
REQ-038 Macro LCD_REFRESH_AUTO_EN defined: in IDLE a counter SHALL count to REFRESH_PERIOD-1, then self-start using the current line* inputs. The counter SHALL clear on any start or done.
REQ-039 Macro LCD_REFRESH_AUTO_EN undefined: refresh SHALL occur only on start, and no counter SHALL be synthesized.

Verification
REQ-040 With line0 = menu 0, line1 = menu 3, and lcd_ready=1, start -> 0x80 then "MAIN MENU MASTER", then 0xC0 then "Display Local   ", then done; 34 handshakes.
REQ-041 With line1 = local, half=1, and the RAM model returning 0x07 at address 20 -> char 4 of line 1 is 0x20; other addresses pass through.
REQ-042 lcd_ready held 0 for 50 cycles during char 5 -> lcd_valid and lcd_data stable all 50 cycles; no byte is lost or duplicated.
REQ-043 start pulsed at transfer 10 of a refresh -> ignored; exactly 34 transfers and one done.
REQ-044 reset at transfer 20 with lcd_valid=1 -> next cycle all outputs are at reset values; no done; a following start yields a full 34-transfer refresh.
REQ-045 LCD_REFRESH_AUTO_EN defined with REFRESH_PERIOD=100 -> a refresh begins 100 cycles after done with no start; undefined -> no refresh for 1000 cycles.
